// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_hs/chain handshake monitor with saturating perf counters and a req/ack read port.
// Optional min-latency tracking is built when APMON_MIN_LAT_EN is defined.
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_end,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] sat
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  state_t state_q [NUM_CH];
  state_t state_d [NUM_CH];
  cnt_t   starts_q [NUM_CH], starts_d [NUM_CH];
  cnt_t   dones_q  [NUM_CH], dones_d  [NUM_CH];
  cnt_t   busy_q   [NUM_CH], busy_d   [NUM_CH];
  cnt_t   stall_q  [NUM_CH], stall_d  [NUM_CH];
  cnt_t   last_q   [NUM_CH], last_d   [NUM_CH];
  cnt_t   max_q    [NUM_CH], max_d    [NUM_CH];
  cnt_t   iters_q  [NUM_CH], iters_d  [NUM_CH];
  cnt_t   lat_q    [NUM_CH], lat_d    [NUM_CH];
`ifdef APMON_MIN_LAT_EN
  cnt_t   min_q    [NUM_CH], min_d    [NUM_CH];
`endif
  logic [NUM_CH-1:0] sat_d;
  cnt_t              rd_val;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin : ch_next
      cnt_t lat_val;
      logic lat_ev;
      logic ovf;
      lat_val     = '0;
      lat_ev      = 1'b0;
      ovf         = 1'b0;
      state_d[i]  = state_q[i];
      starts_d[i] = starts_q[i];
      dones_d[i]  = dones_q[i];
      busy_d[i]   = busy_q[i];
      stall_d[i]  = stall_q[i];
      last_d[i]   = last_q[i];
      max_d[i]    = max_q[i];
      iters_d[i]  = iters_q[i];
      lat_d[i]    = lat_q[i];
`ifdef APMON_MIN_LAT_EN
      min_d[i]    = min_q[i];
`endif
      sat_d[i]    = sat[i];
      if (clear) begin
        state_d[i]  = IDLE;
        starts_d[i] = '0;
        dones_d[i]  = '0;
        busy_d[i]   = '0;
        stall_d[i]  = '0;
        last_d[i]   = '0;
        max_d[i]    = '0;
        iters_d[i]  = '0;
        lat_d[i]    = '0;
`ifdef APMON_MIN_LAT_EN
        min_d[i]    = '1;
`endif
        sat_d[i]    = 1'b0;
      end else if (enable) begin
        if (ap_start[i] && ap_ready[i]) begin
          ovf         = ovf | (starts_q[i] == CNT_MAX);
          starts_d[i] = sat_inc(starts_q[i]);
        end
        if (ap_done[i]) begin
          ovf        = ovf | (dones_q[i] == CNT_MAX);
          dones_d[i] = sat_inc(dones_q[i]);
        end
        if (iter_end[i]) begin
          ovf        = ovf | (iters_q[i] == CNT_MAX);
          iters_d[i] = sat_inc(iters_q[i]);
        end
        unique case (state_q[i])
          IDLE: begin
            // A done coinciding with the start is a zero-latency transaction; no BUSY cycle is spent.
            if (ap_start[i]) begin
              if (ap_done[i]) begin
                lat_ev     = 1'b1;
                state_d[i] = ap_continue[i] ? IDLE : HOLD;
              end else begin
                state_d[i] = BUSY;
                lat_d[i]   = '0;
              end
            end
          end
          BUSY: begin
            ovf       = ovf | (busy_q[i] == CNT_MAX) | (lat_q[i] == CNT_MAX);
            busy_d[i] = sat_inc(busy_q[i]);
            lat_d[i]  = sat_inc(lat_q[i]);
            if (ap_done[i]) begin
              lat_ev  = 1'b1;
              lat_val = sat_inc(lat_q[i]);
              if (!ap_continue[i]) begin
                state_d[i] = HOLD;
              end else if (ap_start[i]) begin
                state_d[i] = BUSY;
                lat_d[i]   = '0;
              end else begin
                state_d[i] = IDLE;
              end
            end
          end
          HOLD: begin
            ovf        = ovf | (stall_q[i] == CNT_MAX);
            stall_d[i] = sat_inc(stall_q[i]);
            if (ap_continue[i]) begin
              state_d[i] = ap_start[i] ? BUSY : IDLE;
              lat_d[i]   = '0;
            end
          end
          default: state_d[i] = IDLE;
        endcase
        if (lat_ev) begin
          last_d[i] = lat_val;
          if (lat_val > max_q[i]) max_d[i] = lat_val;
`ifdef APMON_MIN_LAT_EN
          if (lat_val < min_q[i]) min_d[i] = lat_val;
`endif
        end
        if (ovf) sat_d[i] = 1'b1;
      end
    end
  end

  // Channels that do not exist simply never match, so out-of-range reads return zero.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          3'd0: rd_val = starts_q[i];
          3'd1: rd_val = dones_q[i];
          3'd2: rd_val = busy_q[i];
          3'd3: rd_val = stall_q[i];
          3'd4: rd_val = last_q[i];
          3'd5: rd_val = max_q[i];
`ifdef APMON_MIN_LAT_EN
          3'd6: rd_val = min_q[i];
`else
          3'd6: rd_val = '0;
`endif
          default: rd_val = iters_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        starts_q[i] <= '0;
        dones_q[i]  <= '0;
        busy_q[i]   <= '0;
        stall_q[i]  <= '0;
        last_q[i]   <= '0;
        max_q[i]    <= '0;
        iters_q[i]  <= '0;
        lat_q[i]    <= '0;
`ifdef APMON_MIN_LAT_EN
        min_q[i]    <= '1;
`endif
      end
      sat     <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        starts_q[i] <= starts_d[i];
        dones_q[i]  <= dones_d[i];
        busy_q[i]   <= busy_d[i];
        stall_q[i]  <= stall_d[i];
        last_q[i]   <= last_d[i];
        max_q[i]    <= max_d[i];
        iters_q[i]  <= iters_d[i];
        lat_q[i]    <= lat_d[i];
`ifdef APMON_MIN_LAT_EN
        min_q[i]    <= min_d[i];
`endif
      end
      sat <= sat_d;
      // A read in the clear cycle still returns the pre-clear snapshot.
      if (rd_req) begin
        rd_ack  <= 1'b1;
        rd_data <= rd_val;
      end else if (clear) begin
        rd_ack  <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_ack  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench for ap_ctrl_perf_monitor (NUM_CH=5 so rd_ch 5..7 are out of range, CNT_W=8).
module tb_ap_ctrl_perf_monitor;

  localparam int NCH = 5;
  localparam int CW  = 8;
`ifdef APMON_MIN_LAT_EN
  localparam logic [CW-1:0] MIN_RST = 8'hFF;
  localparam bit            MIN_EN  = 1'b1;
`else
  localparam logic [CW-1:0] MIN_RST = 8'h00;
  localparam bit            MIN_EN  = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset, enable, clear;
  logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue, iter_end;
  logic           rd_req;
  logic [2:0]     rd_ch;
  logic [2:0]     rd_sel;
  logic           rd_ack;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] sat;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic        req_seen;

  ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .iter_end(iter_end),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_ack(rd_ack), .rd_data(rd_data), .sat(sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input int ch, input int sel, input logic [63:0] exp, input string tag,
                    input bit with_clr = 1'b0);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    rd_ch  = ch[2:0];
    rd_sel = sel[2:0];
    rd_req = 1'b1;
    clear  = with_clr;
    tick();
    rd_req = 1'b0;
    clear  = 1'b0;
  endtask

  // Every sampled request must produce an ack one cycle later carrying the queued expectation.
  initial begin
    forever begin
      @(posedge clock);
      req_seen = rd_req;
      #2;
      if (req_seen || rd_ack) begin
        check("rd_ack_timing", rd_ack, req_seen);
        if (rd_ack) begin
          if (exp_q.size() == 0) check("sb_unexpected_ack", exp_q.size(), 1);
          else check(tag_q.pop_front(), rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1; iter_end = '0;
    rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
    tick(2);
    #2 reset = 1'b0;
    tick();
    check("rst_rd_ack", rd_ack, 1'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_sat", sat, 0);
    rd(0, 0, 0, "rst_starts");
    rd(0, 6, MIN_RST, "rst_min_lat");

    // ch0 single transaction, latency 13
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick(); ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    tick(12);
    ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
    rd(0, 0, 1,  "t1_starts");
    rd(0, 1, 1,  "t1_dones");
    rd(0, 4, 13, "t1_last_lat");
    rd(0, 5, 13, "t1_max_lat");
    rd(0, 2, 13, "t1_busy_cyc");
    rd(0, 3, 0,  "t1_stall_cyc");
    rd(0, 6, MIN_EN ? 13 : 0, "t1_min_lat");

    // ch1 done with continue low, then continue+start restarts it
    ap_start[1] = 1'b1; ap_ready[1] = 1'b1; tick(); ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    tick(3);
    ap_done[1] = 1'b1; ap_continue[1] = 1'b0; tick(); ap_done[1] = 1'b0;
    tick(4);
    ap_continue[1] = 1'b1; ap_start[1] = 1'b1; ap_ready[1] = 1'b1; tick();
    ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    ap_done[1] = 1'b1; tick(); ap_done[1] = 1'b0;
    rd(1, 3, 5, "t2_stall_cyc");
    rd(1, 0, 2, "t2_starts");
    rd(1, 1, 2, "t2_dones");
    rd(1, 2, 5, "t2_busy_cyc");
    rd(1, 4, 1, "t2_last_lat");
    rd(1, 5, 4, "t2_max_lat");

    // ch2 back-to-back latencies 3, 9, 2
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick(); ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    tick(2);
    ap_done[2] = 1'b1; ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick();
    ap_done[2] = 1'b0; ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    tick(8);
    ap_done[2] = 1'b1; ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick();
    ap_done[2] = 1'b0; ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    tick(1);
    ap_done[2] = 1'b1; tick(); ap_done[2] = 1'b0;
    rd(2, 4, 2,  "t3_last_lat");
    rd(2, 5, 9,  "t3_max_lat");
    rd(2, 6, MIN_EN ? 2 : 0, "t3_min_lat");
    rd(2, 1, 3,  "t3_dones");
    rd(2, 0, 3,  "t3_starts");
    rd(2, 2, 14, "t3_busy_cyc");
    check("t3_sat_clear", sat, 0);

    // ch3 iteration counter saturation
    iter_end[3] = 1'b1; tick(300); iter_end[3] = 1'b0;
    check("t4_sat", sat, 5'b01000);
    rd(3, 7, 255, "t4_iters_ch3");
    rd(0, 7, 0,   "t4_iters_ch0");
    rd(2, 1, 3,   "t4_dones_ch2");
    rd(5, 0, 0,   "t5_oor_ch5");
    rd(7, 1, 0,   "t5_oor_ch7");
    rd(3, 7, 255, "t5_read_with_clear", 1'b1);
    check("t4_sat_after_clear", sat, 0);
    #2 clear = 1'b1; tick(); clear = 1'b0;
    check("clr_rd_data", rd_data, 0);
    check("clr_rd_ack", rd_ack, 1'b0);
    rd(3, 7, 0, "t4_iters_cleared");
    rd(0, 0, 0, "t4_starts_cleared");
    rd(2, 5, 0, "t4_max_cleared");
    rd(0, 6, MIN_RST, "t4_min_cleared");

    // enable dropped mid-transaction on ch0
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick(); ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    tick(2);
    enable = 1'b0; tick(2);
    ap_done[0] = 1'b1; iter_end[0] = 1'b1; tick(); ap_done[0] = 1'b0; iter_end[0] = 1'b0;
    tick(2);
    rd(0, 2, 2, "t7_busy_frozen");
    enable = 1'b1; tick(2);
    ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
    rd(0, 4, 5, "t7_last_lat");
    rd(0, 1, 1, "t7_dones");
    rd(0, 7, 0, "t7_iters");
    rd(0, 2, 5, "t7_busy_cyc");

    // async reset while ch0 busy
    iter_end[1] = 1'b1; tick(256); iter_end[1] = 1'b0;
    check("t6_sat_ch1", sat, 5'b00010);
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick(); ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    tick(2);
    rd(1, 7, 255, "t6_iters_ch1");
    #2 reset = 1'b1;
    #1;
    check("t6_async_rd_ack", rd_ack, 1'b0);
    check("t6_async_rd_data", rd_data, 0);
    check("t6_async_sat", sat, 0);
    tick();
    #2 reset = 1'b0;
    tick();
    ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
    rd(0, 1, 0 + 1, "t6_dones");
    rd(0, 0, 0, "t6_starts");
    rd(0, 2, 0, "t6_busy_cyc");
    rd(0, 4, 0, "t6_last_lat");
    rd(1, 7, 0, "t6_iters_ch1");

    tick(2);
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
